// File: rtl/cubo_caida_pkg.sv
`default_nettype none
// =====================================================================
// cubo_caida_pkg : screen limits, refresh line and game-state encoding
// Rev 1.0
// =====================================================================
package cubo_caida_pkg;

  localparam int MAX_X          = 640;
  localparam int MAX_Y          = 480;
  localparam int LINEA_REFRESCO = 481;
  localparam int CUBO_TAM       = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SPAWN     = 3'd1,
    FALLING   = 3'd2,
    CAUGHT    = 3'd3,
    MISSED    = 3'd4,
    GAME_OVER = 3'd5
  } estado_t;

endpackage
`default_nettype wire

// File: rtl/cubo_caida_lfsr_aleatorio.sv
`default_nettype none
// =====================================================================
// lfsr_aleatorio : 10-bit Fibonacci LFSR (taps 10,7), free-running
// Rev 1.0
// =====================================================================
module lfsr_aleatorio #(
  parameter logic [9:0] SEMILLA = 10'h2A5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [9:0] lfsr_o
);

  logic [9:0] lfsr_q;
  logic [9:0] lfsr_d;

  always_comb lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) lfsr_q <= SEMILLA;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/cubo_caida.sv
`default_nettype none
// =====================================================================
// cubo_caida : falling cube, catch/miss detection, score and lives
// Optional: CUBO_VIDA_EXTRA_EN grants a life every 16th catch.
// Rev 1.0
// =====================================================================
module cubo_caida
  import cubo_caida_pkg::*;
#(
  parameter int         CANASTA_W  = 96,
  parameter int         CANASTA_Y0 = 416,
  parameter int         VEL_MAX    = 4,
  parameter logic [9:0] SEMILLA    = 10'h2A5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [9:0] pixel_x_i,
  input  logic [9:0] pixel_y_i,
  input  logic [9:0] pos_x_canasta_i,
  output logic       pintar_cubo_o,
  output logic       atrapado_o,
  output logic       perdido_o,
  output logic [7:0] puntaje_o,
  output logic [1:0] vidas_o,
  output logic       fin_juego_o
);

  localparam logic [10:0] C_TAM      = 11'(CUBO_TAM);
  localparam logic [10:0] C_ANCHO    = 11'(CANASTA_W);
  localparam logic [10:0] C_Y0       = 11'(CANASTA_Y0);
  localparam logic [10:0] C_LIMITE_Y = 11'(MAX_Y - CUBO_TAM);
  localparam logic [10:0] C_LINEA    = 11'(LINEA_REFRESCO);
  localparam logic [2:0]  C_VEL_MAX  = 3'(VEL_MAX);

  estado_t     estado_q, estado_d;
  logic [10:0] cubo_x_q, cubo_x_d;
  logic [10:0] cubo_y_q, cubo_y_d;
  logic [2:0]  vel_q, vel_d;
  logic [7:0]  puntaje_q, puntaje_d;
  logic [1:0]  vidas_q, vidas_d;
  logic [7:0]  capturas_q, capturas_d;

  logic [9:0]  lfsr;
  logic        lfsr_unused;
  logic        tick;
  logic [10:0] x_spawn;
  logic [10:0] canasta_x;
  logic [10:0] y_sig;
  logic [7:0]  capturas_sig;
  logic        en_banda;
  logic        solape;
  logic        fondo;

  lfsr_aleatorio #(
    .SEMILLA (SEMILLA)
  ) u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .lfsr_o  (lfsr)
  );

  // Only 9 LFSR bits feed the spawn column so it stays on screen.
  assign lfsr_unused  = lfsr[9];
  assign x_spawn      = {2'b00, lfsr[8:0]} + C_TAM;
  assign tick         = ({1'b0, pixel_y_i} == C_LINEA) && (pixel_x_i == 10'd0);
  assign canasta_x    = {1'b0, pos_x_canasta_i};
  assign y_sig        = cubo_y_q + {8'd0, vel_q};
  assign capturas_sig = capturas_q + 8'd1;
  assign en_banda     = (cubo_y_q + C_TAM) >= C_Y0;
  assign solape       = ((cubo_x_q + C_TAM) > canasta_x) && (cubo_x_q <= (canasta_x + C_ANCHO));
  assign fondo        = y_sig >= C_LIMITE_Y;

  always_comb begin
    estado_d   = estado_q;
    cubo_x_d   = cubo_x_q;
    cubo_y_d   = cubo_y_q;
    vel_d      = vel_q;
    puntaje_d  = puntaje_q;
    vidas_d    = vidas_q;
    capturas_d = capturas_q;
    case (estado_q)
      IDLE: if (start_i) estado_d = SPAWN;
      SPAWN: begin
        cubo_x_d = x_spawn;
        cubo_y_d = '0;
        estado_d = FALLING;
      end
      FALLING: if (tick) begin
        // Catch wins over miss when both hold on the same frame.
        if (en_banda && solape) estado_d = CAUGHT;
        else if (fondo)         estado_d = MISSED;
        else                    cubo_y_d = y_sig;
      end
      CAUGHT: begin
        if (puntaje_q != 8'hFF) puntaje_d = puntaje_q + 8'd1;
        capturas_d = capturas_sig;
        if ((capturas_sig[2:0] == 3'd0) && (vel_q < C_VEL_MAX)) vel_d = vel_q + 3'd1;
`ifdef CUBO_VIDA_EXTRA_EN
        if ((capturas_sig[3:0] == 4'd0) && (vidas_q != 2'd3)) vidas_d = vidas_q + 2'd1;
`endif
        estado_d = SPAWN;
      end
      MISSED: begin
        vidas_d  = vidas_q - 2'd1;
        estado_d = (vidas_q == 2'd1) ? GAME_OVER : SPAWN;
      end
      GAME_OVER: if (start_i) begin
        puntaje_d  = '0;
        vidas_d    = 2'd3;
        vel_d      = 3'd1;
        capturas_d = '0;
        estado_d   = SPAWN;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      estado_q   <= IDLE;
      cubo_x_q   <= '0;
      cubo_y_q   <= '0;
      vel_q      <= 3'd1;
      puntaje_q  <= '0;
      vidas_q    <= 2'd3;
      capturas_q <= '0;
    end else begin
      estado_q   <= estado_d;
      cubo_x_q   <= cubo_x_d;
      cubo_y_q   <= cubo_y_d;
      vel_q      <= vel_d;
      puntaje_q  <= puntaje_d;
      vidas_q    <= vidas_d;
      capturas_q <= capturas_d;
    end
  end

  assign pintar_cubo_o = (estado_q == FALLING)
                      && ({1'b0, pixel_x_i} >= cubo_x_q) && ({1'b0, pixel_x_i} < (cubo_x_q + C_TAM))
                      && ({1'b0, pixel_y_i} >= cubo_y_q) && ({1'b0, pixel_y_i} < (cubo_y_q + C_TAM));
  assign atrapado_o    = (estado_q == CAUGHT);
  assign perdido_o     = (estado_q == MISSED);
  assign fin_juego_o   = (estado_q == GAME_OVER);
  assign puntaje_o     = puntaje_q;
  assign vidas_o       = vidas_q;

endmodule
`default_nettype wire

// File: tb/tb_cubo_caida.sv
`default_nettype none
// =====================================================================
// tb_cubo_caida : randomized game play against a game-level reference
// Rev 1.0
// =====================================================================
module tb_cubo_caida;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [9:0] pos_x;
  logic       pintar;
  logic       atrapado;
  logic       perdido;
  logic [7:0] puntaje;
  logic [1:0] vidas;
  logic       fin;

  always #10 clk = ~clk;

  cubo_caida dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .start_i         (start),
    .pixel_x_i       (pixel_x),
    .pixel_y_i       (pixel_y),
    .pos_x_canasta_i (pos_x),
    .pintar_cubo_o   (pintar),
    .atrapado_o      (atrapado),
    .perdido_o       (perdido),
    .puntaje_o       (puntaje),
    .vidas_o         (vidas),
    .fin_juego_o     (fin)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Pseudo-random source as defined: shift left, feedback = bit10 ^ bit7.
  logic [9:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 10'h2A5;
    else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  typedef struct {
    bit caught;
    int ticks;
    int score;
    int lives;
  } exp_t;

  exp_t sb[$];
  int   ticks_cube = 0;
  int   m_catches, m_score, m_lives;
  bit   m_over;

  initial begin
    bit   pend;
    exp_t cur;
    pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("score_after_pulse", puntaje, cur.score);
        check("lives_after_pulse", vidas, cur.lives);
        pend = 0;
      end
      if (!rst && (atrapado || perdido)) begin
        if (sb.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          cur = sb.pop_front();
          check("pulse_kind_catch", atrapado, cur.caught);
          check("pulse_exclusive", atrapado & perdido, 0);
          check("decision_tick", ticks_cube, cur.ticks);
          pend = 1;
        end
      end
    end
  end

  // Called one step after the DUT enters SPAWN; returns one step after
  // it enters SPAWN again (or GAME_OVER).
  task automatic play_cube(input int mode);
    int   x, p, vel, exp_ticks, probe_k, y;
    bit   hit, got;
    exp_t e;
    x = int'(m_lfsr[8:0]) + 32;
    case (mode)
      0:       p = x - 32;
      1:       p = (x >= 96) ? x - 96 : x - 32;
      2:       p = x + 31;
      3:       p = (x >= 97) ? x - 97 : x + 32;
      4:       p = x + 32;
      default: p = (x >= 200) ? 0 : x + 32;
    endcase
    pos_x = 10'(p);
    hit   = (x + 32 > p) && (x <= p + 96);
    vel   = (1 + m_catches / 8 > 4) ? 4 : 1 + m_catches / 8;
    exp_ticks = hit ? (384 + vel - 1) / vel + 1 : (448 + vel - 1) / vel;
    if (hit) begin
      m_catches++;
      if (m_score < 255) m_score++;
`ifdef CUBO_VIDA_EXTRA_EN
      if ((m_catches % 16 == 0) && (m_lives < 3)) m_lives++;
`endif
    end else begin
      m_lives--;
      if (m_lives == 0) m_over = 1;
    end
    e.caught = hit; e.ticks = exp_ticks; e.score = m_score; e.lives = m_lives;
    sb.push_back(e);

    @(posedge clk); #1;
    pixel_x = 10'(x); pixel_y = 10'd0; #1;
    check("paint_spawn_corner", pintar, 1);
    pixel_x = 10'(x - 1); #1;
    check("paint_left_outside", pintar, 0);

    probe_k    = $urandom_range(1, exp_ticks - 2);
    ticks_cube = 0;
    got        = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      pixel_x = 10'd0; pixel_y = 10'd481;
      start   = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      ticks_cube++;
      #1;
      start = 1'b0;
      if (atrapado || perdido) got = 1;
      else if (ticks_cube == probe_k) begin
        y = probe_k * vel;
        pixel_x = 10'(x + 31); pixel_y = 10'(y + 31); #1;
        check("paint_inside_falling", pintar, 1);
        pixel_x = 10'(x); pixel_y = 10'(y + 32); #1;
        check("paint_below_cube", pintar, 0);
      end
    end
    if (!got) begin
      check("decision_timeout", 0, 1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "no catch/miss pulse within bound");
    end
    pixel_x = 10'd0; pixel_y = 10'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    int x;
    rst = 1'b1; start = 1'b0; pixel_x = '0; pixel_y = '0; pos_x = '0;
    m_catches = 0; m_score = 0; m_lives = 3; m_over = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_score", puntaje, 0);
    check("reset_lives", vidas, 3);
    check("reset_game_over", fin, 0);
    check("reset_caught", atrapado, 0);
    check("reset_missed", perdido, 0);
    check("reset_paint", pintar, 0);
    rst = 1'b0;

    pixel_y = 10'd481;
    repeat (3) @(posedge clk);
    #1;
    pixel_y = 10'd0;
    check("idle_no_pulse", atrapado | perdido, 0);

    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    play_cube(0);
    play_cube(5);
    for (int i = 0; i < 32; i++) play_cube($urandom_range(0, 2));
    for (int i = 0; i < 6 && !m_over; i++) play_cube($urandom_range(3, 5));

    check("game_over_flag", fin, 1);
    check("game_over_lives", vidas, 0);
    pixel_y = 10'd481;
    repeat (4) @(posedge clk);
    #1;
    pixel_y = 10'd0;
    check("game_over_holds_flag", fin, 1);
    check("game_over_holds_score", puntaje, m_score);
    check("game_over_no_paint", pintar, 0);

    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    m_catches = 0; m_score = 0; m_lives = 3; m_over = 0;
    check("restart_lives", vidas, 3);
    check("restart_score", puntaje, 0);
    check("restart_flag", fin, 0);
    for (int i = 0; i < 3; i++) play_cube($urandom_range(0, 2));
    check("score_before_reset", puntaje, 3);

    x = int'(m_lfsr[8:0]) + 32;
    @(posedge clk); #1;
    pixel_x = 10'd0; pixel_y = 10'd481;
    repeat (20) @(posedge clk);
    #1;
    pixel_x = 10'(x); pixel_y = 10'd20; #1;
    check("paint_before_reset", pintar, 1);
    rst = 1'b1; #1;
    check("reset_midfall_paint", pintar, 0);
    check("reset_midfall_score", puntaje, 0);
    check("reset_midfall_lives", vidas, 3);
    check("reset_midfall_flag", fin, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cubo_caida.md
Name: cubo_caida

Overview:
- Downstream consumer of the basket block's `pos_x_actual` (here `pos_x_canasta`).
- Spawns one falling cube at a pseudo-random X and moves it down once per frame.
- Detects catch or miss against the basket and keeps score and lives.
- Produces the cube paint signal for the VGA mux and game-status flags for the top level.

Parameters:
- MAX_X, 640, horizontal screen limit in pixels.
- MAX_Y, 480, vertical screen limit in pixels.
- CUBO_TAM, 32, cube side in pixels.
- CANASTA_W, 96, basket width; the basket spans `pos_x_canasta` .. `pos_x_canasta`+CANASTA_W.
- CANASTA_Y0, 416, top row of the basket band.
- VEL_MAX, 4, maximum fall speed in pixels/frame.
- SEMILLA, 10'h2A5, LFSR reset seed; must be nonzero.

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins or restarts a game.
- pixel_x  in  10  current VGA column.
- pixel_y  in  10  current VGA row.
- pos_x_canasta  in  10  basket left edge, from the basket block.
- pintar_cubo  out  1  high when the current pixel lies inside the cube.
- atrapado  out  1  one-cycle pulse on a catch.
- perdido  out  1  one-cycle pulse on a miss.
- puntaje  out  8  catch count, saturating at 255.
- vidas  out  2  lives remaining.
- fin_juego  out  1  high while in GAME_OVER.

Behaviour:
- Frame tick: `tick = (pixel_y==481) && (pixel_x==0)`. It is one cycle per frame and is the only event that moves the cube.
- Reset values (asynchronous):
  - state=IDLE; cubo_x=0; cubo_y=0; vel=1; puntaje=0; vidas=3; catch counter=0; LFSR=SEMILLA.
  - All pulse outputs 0; fin_juego=0; pintar_cubo=0.
- LFSR: 10-bit maximal (taps 10,7), advances every clock outside reset.
- Spawn X = {1'b0, lfsr[8:0]} + 32, giving range 32..543, always within MAX_X-CUBO_TAM.
- IDLE: start -> SPAWN. No other activity.
- SPAWN (1 cycle): latch cubo_x from the LFSR, set cubo_y=0 -> FALLING.
- FALLING: evaluated only on tick, using pre-increment cubo_y.
  - Catch condition:
    - vertical: cubo_y+CUBO_TAM >= CANASTA_Y0, and
    - horizontal overlap: cubo_x+CUBO_TAM > pos_x_canasta && cubo_x <= pos_x_canasta+CANASTA_W.
    - If met -> CAUGHT.
  - Otherwise, if cubo_y+vel >= MAX_Y-CUBO_TAM -> MISSED.
  - Otherwise cubo_y <= cubo_y+vel.
  - Catch has priority over miss on the same tick.
- CAUGHT (1 cycle):
  - atrapado=1; puntaje+1, saturating at 255; catch counter+1.
  - When the catch counter reaches a multiple of 8, vel+1, saturating at VEL_MAX.
  - -> SPAWN.
- MISSED (1 cycle):
  - perdido=1; vidas-1.
  - If vidas was 1 -> GAME_OVER (vidas=0); else -> SPAWN.
- GAME_OVER: fin_juego=1. start -> puntaje=0, vidas=3, vel=1, catch counter=0, then SPAWN.
- start is ignored in SPAWN, FALLING, CAUGHT and MISSED.
- pintar_cubo is combinational:
  - state==FALLING
  - && cubo_x <= pixel_x < cubo_x+CUBO_TAM
  - && cubo_y <= pixel_y < cubo_y+CUBO_TAM.
- Widths: all position arithmetic is done at 11 bits to avoid wrap; comparisons are unsigned.
- Latency: catch/miss pulses come 1 cycle after the deciding tick; a new cube is visible 2 cycles after the pulse.
- Reset mid-fall: the cube vanishes immediately; the block returns to IDLE.

Optional Feature:
- Macro CUBO_VIDA_EXTRA_EN.
- Defined: every 16th catch, CAUGHT also increments vidas, saturating at 3. If vel also increments on that catch, both updates happen in the same cycle.
- Undefined: vidas only decrements; the catch-16 logic is absent.

Decomposition:
- Shared package:
  - MAX_X, MAX_Y.
  - Refresh line constant 481.
  - State encoding: IDLE=0, SPAWN=1, FALLING=2, CAUGHT=3, MISSED=4, GAME_OVER=5 (3 bits).
  - CUBO_TAM.
- Sub-module lfsr_aleatorio: 10-bit Fibonacci LFSR with seed parameter and async reset. It is natural to split out because the future multi-cube version reuses it.

Test Plan:
- Reset, then start; model ticks; `pos_x_canasta` parked under the spawn X -> atrapado pulse at the tick where cubo_y+32>=416; puntaje=1; new cube at y=0.
- `pos_x_canasta`=0 and cube spawned at X>=200 -> perdido at the tick where cubo_y+1>=448; vidas 3->2.
- Three consecutive misses -> fin_juego=1, vidas=0; further ticks leave the state unchanged; start -> vidas=3, puntaje=0, FALLING within 2 cycles.
- Eight catches -> vel=2 (cube_y advances 2 per tick); force 32 catches -> vel saturates at 4.
- Edge overlap: cubo_x = `pos_x_canasta`+96 -> catch; cubo_x = `pos_x_canasta`+97 -> miss. cubo_x+32 = `pos_x_canasta` -> miss.
- Assert reset during FALLING -> pintar_cubo=0 the same cycle, state IDLE, puntaje=0. With CUBO_VIDA_EXTRA_EN, the 16th catch after one miss restores vidas 2->3.
